// File: rtl/axi_tagctrl_tag_coalescer_pkg.sv
// Shared types for the tag-controller write-path coalescer: FSM state encoding,
// coalescer configuration record and helpers used to size its counters.
package axi_tagctrl_tag_coalescer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } tagc_coal_state_e;

    typedef struct packed {
        int unsigned TagWordWidth;
        int unsigned TimeoutCycles;
    } tagctrl_cfg_t;

    localparam tagctrl_cfg_t TagctrlDefaultCfg = '{TagWordWidth: 64, TimeoutCycles: 16};

    // Idle timer must hold TimeoutCycles itself so the compare can saturate cleanly.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/axi_tagctrl_tag_coalescer_if.sv
// Beat-input / tag-word-output handshake bundle of the tag coalescer.
// slave is the coalescer's view, master the producer/consumer side.
interface axi_tagctrl_tag_coalescer_if #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned TagsPerBeat  = 1,
    parameter int unsigned TagWordWidth = 64
) ();
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [AddrWidth-1:0]    in_addr_i;
    logic [TagsPerBeat-1:0]  in_tags_i;
    logic [TagsPerBeat-1:0]  in_tmask_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [AddrWidth-1:0]    out_addr_o;
    logic [TagWordWidth-1:0] out_data_o;
    logic [TagWordWidth-1:0] out_mask_o;

    modport slave (
        input  in_valid_i, in_addr_i, in_tags_i, in_tmask_i, out_ready_i,
        output in_ready_o, out_valid_o, out_addr_o, out_data_o, out_mask_o
    );

    modport master (
        output in_valid_i, in_addr_i, in_tags_i, in_tmask_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_addr_o, out_data_o, out_mask_o
    );
endinterface

// File: rtl/axi_tagctrl_tag_addr.sv
// Combinational DRAM beat address -> tag-word address and bit offset in the tag region.
// Shared between the tag write coalescer and the tag read path.
module axi_tagctrl_tag_addr
    import axi_tagctrl_tag_coalescer_pkg::*;
#(
    parameter int unsigned          AddrWidth       = 64,
    parameter int unsigned          CapSize         = 128,
    parameter int unsigned          TagWordWidth    = 64,
    parameter logic [AddrWidth-1:0] DRAMMemBase     = 'h8000_0000,
    parameter logic [AddrWidth-1:0] DRAMMemLength   = 'h4000_0000,
    parameter logic [AddrWidth-1:0] TagCacheMemBase = 'hC000_0000,
    parameter int unsigned          BitWidth        = $clog2(TagWordWidth)
) (
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 in_range_o,
    output logic [AddrWidth-1:0] word_addr_o,
    output logic [BitWidth-1:0]  bit_o
);
    localparam int unsigned          CapShift  = $clog2(CapSize / 8);
    localparam logic [AddrWidth-1:0] TagsWord  = AddrWidth'(TagWordWidth);
    localparam logic [AddrWidth-1:0] WordBytes = AddrWidth'(TagWordWidth / 8);

    logic [AddrWidth-1:0] offset;
    logic [AddrWidth-1:0] cap;

    assign offset      = addr_i - DRAMMemBase;
    assign in_range_o  = (addr_i >= DRAMMemBase) && (offset < DRAMMemLength);
    assign cap         = offset >> CapShift;
    assign bit_o       = BitWidth'(cap % TagsWord);
    assign word_addr_o = TagCacheMemBase + (cap / TagsWord) * WordBytes;
endmodule

// File: rtl/axi_tagctrl_tag_coalescer.sv
// Merges per-capability tag updates of DRAM write beats into masked tag-word write
// requests; flushes on word change, full mask, idle timeout or explicit flush.
module axi_tagctrl_tag_coalescer
    import axi_tagctrl_tag_coalescer_pkg::*;
#(
    parameter int unsigned          AddrWidth       = 64,
    parameter int unsigned          DataWidth       = 128,
    parameter int unsigned          CapSize         = 128,
    parameter int unsigned          TagWordWidth    = 64,
    parameter logic [AddrWidth-1:0] DRAMMemBase     = 'h8000_0000,
    parameter logic [AddrWidth-1:0] DRAMMemLength   = 'h4000_0000,
    parameter logic [AddrWidth-1:0] TagCacheMemBase = 'hC000_0000,
    parameter int unsigned          TimeoutCycles   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    axi_tagctrl_tag_coalescer_if.slave   bus,
    output logic                         busy_o,
    output logic                         err_o
);
    localparam int unsigned TagsPerBeat = DataWidth / CapSize;
    localparam int unsigned BitWidth    = $clog2(TagWordWidth);
    localparam int unsigned TimerWidth  = timer_width(TimeoutCycles);
    localparam logic [TimerWidth-1:0] Timeout = TimerWidth'(TimeoutCycles);

    typedef struct packed {
        logic [AddrWidth-1:0]    addr;
        logic [TagWordWidth-1:0] data;
        logic [TagWordWidth-1:0] mask;
    } tag_wr_req_t;

    tagc_coal_state_e        state_q, state_d;
    tag_wr_req_t             req_q, req_d;
    logic [TimerWidth-1:0]   timer_q, timer_d;
    logic                    err_q, err_d;
    logic                    in_ready;

    logic                    in_range;
    logic [AddrWidth-1:0]    word_addr;
    logic [BitWidth-1:0]     bit_off;
    logic [TagWordWidth-1:0] beat_mask;
    logic [TagWordWidth-1:0] beat_tags;
    logic                    no_slots;
    logic                    match;

    axi_tagctrl_tag_addr #(
        .AddrWidth       (AddrWidth),
        .CapSize         (CapSize),
        .TagWordWidth    (TagWordWidth),
        .DRAMMemBase     (DRAMMemBase),
        .DRAMMemLength   (DRAMMemLength),
        .TagCacheMemBase (TagCacheMemBase),
        .BitWidth        (BitWidth)
    ) u_tag_addr (
        .addr_i      (bus.in_addr_i),
        .in_range_o  (in_range),
        .word_addr_o (word_addr),
        .bit_o       (bit_off)
    );

    assign beat_mask = TagWordWidth'(bus.in_tmask_i) << bit_off;
    assign beat_tags = TagWordWidth'(bus.in_tags_i & bus.in_tmask_i) << bit_off;
    assign no_slots  = (bus.in_tmask_i == '0);
    // A beat touching no slot can never disturb the held word, so it always merges.
    assign match     = no_slots || (in_range && (word_addr == req_q.addr));

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        timer_d  = timer_q;
        err_d    = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (!no_slots) begin
                        req_d.addr = word_addr;
                        req_d.data = beat_tags;
                        req_d.mask = beat_mask;
                        timer_d    = '0;
                        state_d    = ACCUM;
                    end
                end
            end
            ACCUM: begin
                in_ready = match;
                if (bus.in_valid_i && match) begin
                    req_d.data = (req_q.data & ~beat_mask) | beat_tags;
                    req_d.mask = req_q.mask | beat_mask;
                    timer_d    = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                // Deciding on the post-merge mask/timer keeps accept -> request at one cycle.
                if ((bus.in_valid_i && !match) || flush_i || (&req_d.mask) ||
                    ((TimeoutCycles != 0) && (timer_d >= Timeout))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (bus.out_ready_i) begin
                    req_d   = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = (state_q == FLUSH);
    assign bus.out_addr_o  = req_q.addr;
    assign bus.out_data_o  = req_q.data;
    assign bus.out_mask_o  = req_q.mask;
    assign busy_o          = (state_q != IDLE);
    assign err_o           = err_q;
endmodule

// File: tb/tb_axi_tagctrl_tag_coalescer.sv
// Directed scoreboard bench for the tag coalescer at CapSize/DataWidth 128, 64-tag words.
module tb_axi_tagctrl_tag_coalescer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic busy, err;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] mask;
    } req_t;
    req_t sb[$];

    always #5 clk = ~clk;

    axi_tagctrl_tag_coalescer_if #(.AddrWidth(64), .TagsPerBeat(1), .TagWordWidth(64)) bus ();

    axi_tagctrl_tag_coalescer dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus),
        .busy_o  (busy),
        .err_o   (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
        req_t r;
        r.addr = a; r.data = d; r.mask = m;
        sb.push_back(r);
        $display("push req addr=%0h data=%0h mask=%0h", a, d, m);
    endtask

    // Output monitor: a handshake completes at the posedge following this sample.
    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            if (sb.size() == 0) begin
                check("req_unexpected", 64'(bus.out_valid_o), 64'd0);
            end else begin
                req_t e;
                e = sb.pop_front();
                $display("req addr=%0h data=%0h mask=%0h", bus.out_addr_o, bus.out_data_o, bus.out_mask_o);
                check("req_addr", bus.out_addr_o, e.addr);
                check("req_data", bus.out_data_o, e.data);
                check("req_mask", bus.out_mask_o, e.mask);
            end
        end
    end

    task automatic send_beat(input logic [63:0] addr, input logic tag);
        bus.in_valid_i = 1'b1;
        bus.in_addr_i  = addr;
        bus.in_tags_i  = tag;
        bus.in_tmask_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) break;
        end
        check("beat_accept", 64'(bus.in_ready_o), 64'd1);
        $display("beat addr=%0h tag=%0d", addr, tag);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.in_tmask_i = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit stable_low;
        bus.in_valid_i  = 1'b0;
        bus.in_addr_i   = '0;
        bus.in_tags_i   = '0;
        bus.in_tmask_i  = '0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_busy",      64'(busy),            64'd0);
        check("rst_err",       64'(err),             64'd0);
        check("rst_out_addr",  bus.out_addr_o,       64'd0);
        check("rst_out_data",  bus.out_data_o,       64'd0);
        check("rst_out_mask",  bus.out_mask_o,       64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two slots of word 0, explicit flush.
        send_beat(64'h8000_0000, 1'b1);
        send_beat(64'h8000_0010, 1'b0);
        check("t1_busy", 64'(busy), 64'd1);
        push(64'hC000_0000, 64'h1, 64'h3);
        pulse_flush();
        drain("t1_drain");

        // Word 1.
        send_beat(64'h8000_0400, 1'b1);
        push(64'hC000_0008, 64'h1, 64'h1);
        pulse_flush();
        drain("t2_drain");

        // Full word fill flushes on its own with no stall.
        push(64'hC000_0000, '1, '1);
        for (int i = 0; i < 64; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_addr_i  = 64'h8000_0000 + 64'(i) * 64'h10;
            bus.in_tags_i  = 1'b1;
            bus.in_tmask_i = 1'b1;
            @(negedge clk);
            check("t3_ready", 64'(bus.in_ready_o), 64'd1);
            @(posedge clk); #1;
        end
        bus.in_valid_i = 1'b0;
        bus.in_tmask_i = 1'b0;
        drain("t3_drain");

        // Word change stalls the new beat until the old word is out.
        send_beat(64'h8000_0000, 1'b1);
        push(64'hC000_0000, 64'h1, 64'h1);
        bus.in_valid_i = 1'b1;
        bus.in_addr_i  = 64'h8000_0800;
        bus.in_tags_i  = 1'b1;
        bus.in_tmask_i = 1'b1;
        @(negedge clk);
        check("t4_stall", 64'(bus.in_ready_o), 64'd0);
        @(posedge clk); #1;
        send_beat(64'h8000_0800, 1'b1);
        push(64'hC000_0010, 64'h1, 64'h1);
        pulse_flush();
        drain("t4_drain");

        // Idle timeout with a back-pressured consumer.
        bus.out_ready_i = 1'b0;
        send_beat(64'h8000_0020, 1'b1);
        push(64'hC000_0000, 64'h4, 64'h4);
        stable_low = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.out_valid_o !== 1'b0) stable_low = 1'b0;
        end
        check("t5_quiet_16", 64'(stable_low), 64'd1);
        @(negedge clk);
        check("t5_valid_17", 64'(bus.out_valid_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("t5_hold_addr",  bus.out_addr_o, 64'hC000_0000);
            check("t5_hold_data",  bus.out_data_o, 64'h4);
            check("t5_hold_mask",  bus.out_mask_o, 64'h4);
        end
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        drain("t5_drain");

        // Out-of-range beat.
        send_beat(64'h7FFF_FFF0, 1'b1);
        @(negedge clk);
        check("t6_err_pulse", 64'(err), 64'd1);
        @(negedge clk);
        check("t6_err_clear", 64'(err), 64'd0);
        check("t6_err_busy",  64'(busy), 64'd0);
        check("t6_err_noreq", 64'(bus.out_valid_o), 64'd0);
        @(posedge clk); #1;

        // Reset while presenting a request.
        bus.out_ready_i = 1'b0;
        send_beat(64'h8000_0000, 1'b1);
        pulse_flush();
        @(negedge clk);
        check("t6_in_flush", 64'(bus.out_valid_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(bus.out_valid_o), 64'd0);
        check("t6_rst_busy",  64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        send_beat(64'h8000_0010, 1'b1);
        push(64'hC000_0000, 64'h2, 64'h2);
        pulse_flush();
        drain("t6_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
